// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: reader FSM states and the active-low digit patterns
// used by both the seg7 encoder and the seg7_reader decoder.
package seg7_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, DECODE} reader_state_t;

  // Active-low, bit0 = segment a .. bit6 = segment g
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational inverse of the seg7 encoder: classifies an active-low pattern as a
// BCD digit, blank, or neither.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat,
  output logic       is_digit,
  output logic       is_blank,
  output logic [3:0] bcd
);

  always_comb begin
    is_digit = 1'b1;
    is_blank = 1'b0;
    bcd      = '0;
    case (pat)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: begin
        is_digit = 1'b0;
        is_blank = 1'b1;
      end
      default:   is_digit = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Samples an active-low segment bus, waits for it to settle, decodes it to BCD and
// shifts each decoded digit into a packed NUM_DIGITS register.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [6:0]                        seg_in,
  input  logic                              seg_strobe,
  input  logic                              clear,
  output logic                              digit_valid,
  output logic [3:0]                        digit_out,
  output logic                              seg_err,
  output logic [4*NUM_DIGITS-1:0]           digits,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   count,
  output logic                              full
);

  localparam int CW   = $clog2(STABLE_CYCLES + 1);
  localparam int CNTW = $clog2(NUM_DIGITS + 1);

  reader_state_t state, state_nxt;
  logic [6:0]    pat, pat_nxt;
  logic [CW-1:0] stab_cnt, stab_nxt;

  logic       is_digit, is_blank;
  logic [3:0] bcd;
  logic       write;
  logic [4*NUM_DIGITS-1:0] digits_shift, digits_single;

  seg7_decode u_decode (
    .pat      (pat),
    .is_digit (is_digit),
    .is_blank (is_blank),
    .bcd      (bcd)
  );

  // Exit SETTLE on the edge where the count reaches STABLE_CYCLES, so a steady bus
  // produces digit_valid exactly STABLE_CYCLES+1 cycles after its strobe.
  always_comb begin
    state_nxt = state;
    pat_nxt   = pat;
    stab_nxt  = stab_cnt;
    case (state)
      IDLE: begin
        if (seg_strobe) begin
          pat_nxt   = seg_in;
          stab_nxt  = CW'(1);
          state_nxt = (STABLE_CYCLES == 1) ? DECODE : SETTLE;
        end
      end
      SETTLE: begin
        if (seg_in == pat) begin
          stab_nxt = stab_cnt + 1'b1;
          if (stab_nxt == CW'(STABLE_CYCLES)) state_nxt = DECODE;
        end else begin
          pat_nxt  = seg_in;
          stab_nxt = CW'(1);
        end
      end
      DECODE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign write = (state == DECODE) && is_digit;

  always_comb begin
    digits_shift       = '0;
    digits_shift[3:0]  = bcd;
    for (int unsigned i = 1; i < NUM_DIGITS; i++)
      digits_shift[4*i +: 4] = digits[4*(i-1) +: 4];
    digits_single      = '0;
    digits_single[3:0] = bcd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pat         <= SEG_BLANK;
      stab_cnt    <= '0;
      digit_valid <= 1'b0;
      seg_err     <= 1'b0;
      digit_out   <= '0;
      digits      <= '0;
      count       <= '0;
    end else begin
      state       <= state_nxt;
      pat         <= pat_nxt;
      stab_cnt    <= stab_nxt;
      digit_valid <= write;
      seg_err     <= (state == DECODE) && !is_digit && !is_blank;
      if (write) digit_out <= bcd;

      if (clear) begin
        digits <= write ? digits_single : '0;
        count  <= write ? CNTW'(1) : '0;
      end else if (write) begin
        digits <= digits_shift;
        if (count != CNTW'(NUM_DIGITS)) count <= count + 1'b1;
      end
    end
  end

  assign full = (count == CNTW'(NUM_DIGITS));

endmodule

// File: tb/tb_seg7_reader.sv
// Scoreboard bench for seg7_reader: the driver queues expected pulses (kind, value,
// arrival cycle) and a negedge monitor checks each pulse as it appears.
module tb_seg7_reader;

  localparam int ND = 4;
  localparam int SC = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    seg_in;
  logic          seg_strobe;
  logic          clear;
  logic          digit_valid;
  logic [3:0]    digit_out;
  logic          seg_err;
  logic [4*ND-1:0] digits;
  logic [$clog2(ND+1)-1:0] count;
  logic          full;

  seg7_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_in      (seg_in),
    .seg_strobe  (seg_strobe),
    .clear       (clear),
    .digit_valid (digit_valid),
    .digit_out   (digit_out),
    .seg_err     (seg_err),
    .digits      (digits),
    .count       (count),
    .full        (full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       is_err;
    logic [3:0] val;
    int         at;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  logic [6:0] pats [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && (digit_valid || seg_err)) begin
      chk("pulse_exclusive", {31'd0, digit_valid && seg_err}, 32'd0);
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got valid=%0b err=%0b expected none (cycle %0d)",
                 digit_valid, seg_err, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("pulse_kind", {31'd0, seg_err}, {31'd0, e.is_err});
        chk("digit_out", {28'd0, digit_out}, {28'd0, e.val});
        chk("latency", cyc, e.at);
      end
    end
  end

  task automatic strobe_pat(input logic [6:0] p);
    @(negedge clk);
    seg_in     = p;
    seg_strobe = 1'b1;
    @(negedge clk);
    seg_strobe = 1'b0;
  endtask

  task automatic push_digit(input logic [3:0] v, input int at);
    exp_t e;
    e.is_err = 1'b0;
    e.val    = v;
    e.at     = at;
    sbq.push_back(e);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    int t0;
    exp_t e;
    reset      = 1'b1;
    seg_in     = 7'h7F;
    seg_strobe = 1'b0;
    clear      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid",  {31'd0, digit_valid}, 32'd0);
    chk("rst_err",    {31'd0, seg_err}, 32'd0);
    chk("rst_digit",  {28'd0, digit_out}, 32'd0);
    chk("rst_digits", {16'd0, digits}, 32'd0);
    chk("rst_count",  {29'd0, count}, 32'd0);
    chk("rst_full",   {31'd0, full}, 32'd0);
    reset = 1'b0;

    // Loopback 0..9
    for (int d = 0; d < 10; d++) begin
      @(negedge clk);
      seg_in     = pats[d];
      seg_strobe = 1'b1;
      push_digit(4'(d), cyc + SC + 1);
      @(negedge clk);
      seg_strobe = 1'b0;
      repeat (5) @(negedge clk);
    end
    chk("loop_digits", {16'd0, digits}, 32'h6789);
    chk("loop_count",  {29'd0, count}, 32'd4);
    chk("loop_full",   {31'd0, full}, 32'd1);

    pulse_clear();
    chk("clr_digits", {16'd0, digits}, 32'd0);
    chk("clr_count",  {29'd0, count}, 32'd0);
    chk("clr_full",   {31'd0, full}, 32'd0);

    // Glitch: 3 then 2 one cycle later restarts the count
    @(negedge clk);
    seg_in     = 7'b0110000;
    seg_strobe = 1'b1;
    t0         = cyc;
    push_digit(4'd2, t0 + SC + 2);
    @(negedge clk);
    seg_strobe = 1'b0;
    seg_in     = 7'b0100100;
    repeat (6) @(negedge clk);
    chk("glitch_count",  {29'd0, count}, 32'd1);
    chk("glitch_digits", {16'd0, digits}, 32'h0002);

    // Invalid pattern -> seg_err, digit_out keeps 2
    @(negedge clk);
    seg_in     = 7'b0000001;
    seg_strobe = 1'b1;
    e.is_err = 1'b1;
    e.val    = 4'd2;
    e.at     = cyc + SC + 1;
    sbq.push_back(e);
    @(negedge clk);
    seg_strobe = 1'b0;
    repeat (5) @(negedge clk);
    chk("err_count", {29'd0, count}, 32'd1);

    // Blank -> silent
    strobe_pat(7'b1111111);
    repeat (6) @(negedge clk);
    chk("blank_count", {29'd0, count}, 32'd1);
    chk("blank_digit", {28'd0, digit_out}, 32'd2);

    // Overflow
    pulse_clear();
    for (int d = 1; d <= 5; d++) begin
      @(negedge clk);
      seg_in     = pats[d];
      seg_strobe = 1'b1;
      push_digit(4'(d), cyc + SC + 1);
      @(negedge clk);
      seg_strobe = 1'b0;
      repeat (5) @(negedge clk);
    end
    chk("ovf_digits", {16'd0, digits}, 32'h2345);
    chk("ovf_count",  {29'd0, count}, 32'd4);
    chk("ovf_full",   {31'd0, full}, 32'd1);

    // clear coincident with the write of 7
    @(negedge clk);
    seg_in     = pats[7];
    seg_strobe = 1'b1;
    t0         = cyc;
    push_digit(4'd7, t0 + SC + 1);
    @(negedge clk);
    seg_strobe = 1'b0;
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clrwr_count",  {29'd0, count}, 32'd1);
    chk("clrwr_digits", {16'd0, digits}, 32'h0007);
    chk("clrwr_full",   {31'd0, full}, 32'd0);
    repeat (3) @(negedge clk);

    // Reset during SETTLE discards the in-flight digit
    @(negedge clk);
    seg_in     = pats[5];
    seg_strobe = 1'b1;
    @(negedge clk);
    seg_strobe = 1'b0;
    reset      = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst2_valid",  {31'd0, digit_valid}, 32'd0);
    chk("rst2_err",    {31'd0, seg_err}, 32'd0);
    chk("rst2_digit",  {28'd0, digit_out}, 32'd0);
    chk("rst2_digits", {16'd0, digits}, 32'd0);
    chk("rst2_count",  {29'd0, count}, 32'd0);
    chk("rst2_full",   {31'd0, full}, 32'd0);

    chk("sb_drained", sbq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
